dpram_be: RTL and testbench

- Parametrised true dual-port RAM, the next generation of the team's dpram.
- Adds per-byte write enables, selectable read latency (1 or 2), and deterministic same-address collision resolution with a sticky collision counter.
- Adds a post-reset clear sequencer that fills the whole array with a known value.
- Sits between the SPI register front-end (port A) and the servo PWM channel engines (port B) as shared setpoint/status storage.

---
 rtl/dpram_be.sv | 166 ++++++++++++++++
 tb/tb_dpram_be.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be.sv
// dpram_be: true dual-port RAM with byte enables, latency 1/2,
// collision resolution + counter, and a post-reset clear sequencer.
// Ports: clk, rst_n (sync, active-low);
//   port A/B: en, we, be, addr, wdata in; rdata, rvalid out.
//   init_busy, collision, collision_cnt status outputs.
module dpram_be #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int B_WINS       = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             a_en,
  input  logic                             a_we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_wdata,
  output logic [DATA_WIDTH-1:0]            a_rdata,
  output logic                             a_rvalid,
  input  logic                             b_en,
  input  logic                             b_we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_wdata,
  output logic [DATA_WIDTH-1:0]            b_rdata,
  output logic                             b_rvalid,
  output logic                             init_busy,
  output logic                             collision,
  output logic [15:0]                      collision_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam bit BWIN = (B_WINS != 0);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("dpram_be: READ_LATENCY must be 1 or 2");
  end
  if (NB * BYTE_WIDTH != DATA_WIDTH) begin : g_bad_dw
    $error("dpram_be: DATA_WIDTH not a multiple of BYTE_WIDTH");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic ready, a_acc, b_acc, a_wr, b_wr, same, col;
  logic [DATA_WIDTH-1:0] a_lm, b_lm, xa, xb;
  logic [DATA_WIDTH-1:0] a_ta, a_tb, b_ta, b_tb;
  logic [DATA_WIDTH-1:0] a_word, b_word;

  assign ready = (state == READY);
  assign a_acc = ready & a_en;
  assign b_acc = ready & b_en;
  assign a_wr  = a_acc & a_we;
  assign b_wr  = b_acc & b_we;
  assign same  = (a_addr == b_addr);
  assign col   = a_acc & b_acc & same & (a_we | b_we);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign a_lm[i*BYTE_WIDTH +: BYTE_WIDTH] =
      {BYTE_WIDTH{a_wr & a_be[i]}};
    assign b_lm[i*BYTE_WIDTH +: BYTE_WIDTH] =
      {BYTE_WIDTH{b_wr & b_be[i]}};
  end

  // Other port's lanes only matter when it hits the same word.
  assign xa = same ? a_lm : '0;
  assign xb = same ? b_lm : '0;

  // Lane ownership; on a doubly-enabled lane the winner takes it.
  assign a_ta = BWIN ? (a_lm & ~xb) : a_lm;
  assign a_tb = BWIN ? xb : (xb & ~a_lm);
  assign b_tb = BWIN ? b_lm : (b_lm & ~xa);
  assign b_ta = BWIN ? (xa & ~b_lm) : xa;

  assign a_word = (mem[a_addr] & ~(a_ta | a_tb))
                | (a_wdata & a_ta) | (b_wdata & a_tb);
  assign b_word = (mem[b_addr] & ~(b_ta | b_tb))
                | (a_wdata & b_ta) | (b_wdata & b_tb);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!ready) begin
        mem[ptr] <= CLEAR_VALUE;
      end else begin
        if (a_wr) mem[a_addr] <= a_word;
        if (b_wr) mem[b_addr] <= b_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= CLEAR;
      ptr           <= '0;
      init_busy     <= 1'b1;
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      collision <= col;
      if (col && collision_cnt != 16'hFFFF)
        collision_cnt <= collision_cnt + 16'd1;
      unique case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (&ptr) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: ;
      endcase
    end
  end

  logic                  a_v1, b_v1;
  logic [DATA_WIDTH-1:0] a_d1, b_d1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      if (a_acc) a_d1 <= a_word;
      if (b_acc) b_d1 <= b_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  a_v2, b_v2;
    logic [DATA_WIDTH-1:0] a_d2, b_d2;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
        a_d2 <= '0;
        b_d2 <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_d2 <= a_d1;
        if (b_v1) b_d2 <= b_d1;
      end
    end
    assign a_rvalid = a_v2;
    assign b_rvalid = b_v2;
    assign a_rdata  = a_d2;
    assign b_rdata  = b_d2;
  end else begin : g_lat1
    assign a_rvalid = a_v1;
    assign b_rvalid = b_v1;
    assign a_rdata  = a_d1;
    assign b_rdata  = b_d1;
  end

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: scoreboard bench for dpram_be, two instances:
// dut0 latency 1 / A wins, dut1 latency 2 / B wins.
module tb_dpram_be;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en, b_we;
  logic [1:0]  a_be, b_be;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic [15:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
  logic        init_busy0, init_busy1;
  logic        collision0, collision1;
  logic [15:0] collision_cnt0, collision_cnt1;

  int total = 0;
  int bad = 0;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic        busy_m;
  int          ptr_m;
  logic        col_m;
  logic [15:0] cnt_m;
  ent_t        qa0[$], qb0[$], qa1[$], qb1[$];

  always #5 clk = ~clk;

  dpram_be #(.READ_LATENCY(1), .B_WINS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
    .init_busy(init_busy0), .collision(collision0),
    .collision_cnt(collision_cnt0)
  );

  dpram_be #(.READ_LATENCY(2), .B_WINS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
    .init_busy(init_busy1), .collision(collision1),
    .collision_cnt(collision_cnt1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mix(
    input logic [15:0] old,
    input logic [15:0] wa, input logic [1:0] bea, input logic ona,
    input logic [15:0] wb, input logic [1:0] beb, input logic onb,
    input logic bwins);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 2; i++) begin
      logic ta, tb;
      ta = ona & bea[i];
      tb = onb & beb[i];
      if (ta && tb)
        r[i*8 +: 8] = bwins ? wb[i*8 +: 8] : wa[i*8 +: 8];
      else if (ta)
        r[i*8 +: 8] = wa[i*8 +: 8];
      else if (tb)
        r[i*8 +: 8] = wb[i*8 +: 8];
    end
    return r;
  endfunction

  task automatic step(
    input logic rst,
    input logic ae, input logic awe, input logic [1:0] abe,
    input logic [7:0] aad, input logic [15:0] awd,
    input logic be_, input logic bwe, input logic [1:0] bbe,
    input logic [7:0] bad_, input logic [15:0] bwd);
    logic rdy, aw, bw, sm;
    logic [15:0] wa0, wb0, wa1, wb1;
    ent_t e [4];
    logic [15:0] od [4];
    logic        ov [4];
    rst_n = rst; a_en = ae; a_we = awe; a_be = abe;
    a_addr = aad; a_wdata = awd;
    b_en = be_; b_we = bwe; b_be = bbe;
    b_addr = bad_; b_wdata = bwd;
    rdy = rst & ~busy_m;
    aw  = rdy & ae & awe;
    bw  = rdy & be_ & bwe;
    sm  = (aad == bad_);
    wa0 = mix(mem0[aad], awd, abe, aw, bwd, bbe, bw && sm, 1'b0);
    wb0 = mix(mem0[bad_], awd, abe, aw && sm, bwd, bbe, bw, 1'b0);
    wa1 = mix(mem1[aad], awd, abe, aw, bwd, bbe, bw && sm, 1'b1);
    wb1 = mix(mem1[bad_], awd, abe, aw && sm, bwd, bbe, bw, 1'b1);
    qa0.push_back({rdy & ae, wa0});
    qb0.push_back({rdy & be_, wb0});
    qa1.push_back({rdy & ae, wa1});
    qb1.push_back({rdy & be_, wb1});
    if (aw) begin mem0[aad] = wa0; mem1[aad] = wa1; end
    if (bw) begin mem0[bad_] = wb0; mem1[bad_] = wb1; end
    if (!rst) begin
      busy_m = 1'b1; ptr_m = 0; col_m = 1'b0; cnt_m = 16'd0;
    end else begin
      col_m = rdy & ae & be_ & sm & (awe | bwe);
      if (col_m && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (busy_m) begin
        ptr_m++;
        if (ptr_m == 256) begin
          busy_m = 1'b0;
          for (int k = 0; k < 256; k++) begin
            mem0[k] = 16'h0000; mem1[k] = 16'h0000;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    e[0] = qa0.pop_front(); e[1] = qb0.pop_front();
    e[2] = qa1.pop_front(); e[3] = qb1.pop_front();
    if (!rst) begin
      for (int k = 0; k < 4; k++) e[k] = '0;
      qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
      qa1.push_back('0); qb1.push_back('0);
    end
    ov[0] = a_rvalid0; ov[1] = b_rvalid0;
    ov[2] = a_rvalid1; ov[3] = b_rvalid1;
    od[0] = a_rdata0; od[1] = b_rdata0;
    od[2] = a_rdata1; od[3] = b_rdata1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rvalid%0d", k), {31'd0, ov[k]}, {31'd0, e[k].v});
      if (e[k].v || !rst)
        chk($sformatf("rdata%0d", k), {16'd0, od[k]}, {16'd0, e[k].d});
    end
    chk("busy0", {31'd0, init_busy0}, {31'd0, busy_m});
    chk("busy1", {31'd0, init_busy1}, {31'd0, busy_m});
    chk("col0", {31'd0, collision0}, {31'd0, col_m});
    chk("col1", {31'd0, collision1}, {31'd0, col_m});
    chk("cnt0", {16'd0, collision_cnt0}, {16'd0, cnt_m});
    chk("cnt1", {16'd0, collision_cnt1}, {16'd0, cnt_m});
  endtask

  task automatic idle();
    step(1, 0, 0, 2'b00, 8'h00, 16'h0, 0, 0, 2'b00, 8'h00, 16'h0);
  endtask

  task automatic rd_a(input logic [7:0] ad);
    step(1, 1, 0, 2'b00, ad, 16'h0, 0, 0, 2'b00, 8'h00, 16'h0);
  endtask

  task automatic wait_init(input int start, input string tag);
    int n;
    n = start;
    while (init_busy0 === 1'b1 && n < 300) begin
      idle();
      n++;
    end
    chk(tag, n, 256);
  endtask

  initial begin
    busy_m = 1'b1; ptr_m = 0; col_m = 1'b0; cnt_m = 16'd0;
    qa1.push_back('0); qb1.push_back('0);
    for (int k = 0; k < 256; k++) begin
      mem0[k] = 16'hxxxx; mem1[k] = 16'hxxxx;
    end
    rst_n = 1'b0;
    {a_en, a_we, b_en, b_we} = '0;
    a_be = '0; b_be = '0; a_addr = '0; b_addr = '0;
    a_wdata = '0; b_wdata = '0;
    #1;
    step(0, 0, 0, 2'b00, 8'h00, 16'h0, 0, 0, 2'b00, 8'h00, 16'h0);
    step(0, 0, 0, 2'b00, 8'h00, 16'h0, 0, 0, 2'b00, 8'h00, 16'h0);
    wait_init(0, "busy_len");

    rd_a(8'h00); rd_a(8'h7F);
    step(1, 1, 0, 2'b00, 8'hFF, 16'h0, 1, 0, 2'b00, 8'h7F, 16'h0);
    idle(); idle();

    step(1, 1, 1, 2'b11, 8'h12, 16'hBEEF, 0, 0, 2'b00, 8'h00, 16'h0);
    rd_a(8'h12);
    idle(); idle();

    step(1, 1, 1, 2'b11, 8'h20, 16'h1234, 0, 0, 2'b00, 8'h00, 16'h0);
    step(1, 0, 0, 2'b00, 8'h00, 16'h0, 1, 1, 2'b10, 8'h20, 16'hAB00);
    step(1, 0, 0, 2'b00, 8'h00, 16'h0, 1, 0, 2'b00, 8'h20, 16'h0);
    idle(); idle();

    step(1, 1, 1, 2'b11, 8'h40, 16'h1111, 1, 1, 2'b01, 8'h40, 16'h2222);
    step(1, 1, 0, 2'b00, 8'h40, 16'h0, 1, 0, 2'b00, 8'h40, 16'h0);
    idle(); idle();

    step(1, 1, 1, 2'b11, 8'h41, 16'h5A5A, 1, 0, 2'b00, 8'h41, 16'h0);
    step(1, 1, 0, 2'b00, 8'h41, 16'h0, 1, 0, 2'b00, 8'h41, 16'h0);
    step(1, 1, 1, 2'b00, 8'h41, 16'hFFFF, 0, 0, 2'b00, 8'h00, 16'h0);
    idle(); idle();

    for (int i = 0; i < 60; i++) begin
      logic [7:0] aa, ba;
      aa = 8'h50 + 8'($urandom_range(0, 3));
      ba = 8'h50 + 8'($urandom_range(0, 3));
      step(1, 1'($urandom), 1'($urandom), 2'($urandom), aa,
           16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
           ba, 16'($urandom));
    end
    idle(); idle();

    step(0, 0, 0, 2'b00, 8'h00, 16'h0, 0, 0, 2'b00, 8'h00, 16'h0);
    for (int i = 0; i < 99; i++) idle();
    rd_a(8'h12);
    step(0, 1, 0, 2'b00, 8'h12, 16'h0, 0, 0, 2'b00, 8'h00, 16'h0);
    rd_a(8'h12);
    wait_init(1, "busy_restart");
    rd_a(8'h12);
    step(1, 0, 0, 2'b00, 8'h00, 16'h0, 1, 0, 2'b00, 8'h40, 16'h0);
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
